// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data-memory responder with request/response handshakes
//
// Ports:
//   clk, reset                         rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready                request handshake; req_write/req_addr/req_wdata sampled at acceptance
//   resp_valid/resp_ready              response handshake; resp_rdata is read data (write data echoed for writes)
//   busy                               a transaction is in flight (state is not IDLE)

module data_mem_responder #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              resp_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              accept;
    logic              enter_resp;

    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // Fields used on the edge that enters RESP. With zero wait states that
    // edge is the acceptance edge, so the live request is used directly.
    logic              com_write;
    logic [ADDR_W-1:0] com_addr;
    logic [DATA_W-1:0] com_wdata;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    assign com_write = (state == S_IDLE) ? req_write : lat_write;
    assign com_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
    assign com_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_nxt = WAIT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                // <= 1 rather than == 1 so a corrupted zero count cannot stall here
                if (cnt <= 4'd1) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            resp_valid <= (state_nxt == S_RESP);
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (enter_resp) begin
                // The array read sees the contents before this edge; for a
                // write the echoed data comes from the request, not the array.
                resp_rdata <= com_write ? com_wdata : mem[com_addr];
            end
        end
    end

    // Array is not reset; the reset gate stops a commit while reset is held.
    always_ff @(posedge clk) begin
        if (enter_resp && com_write && !reset) begin
            mem[com_addr] <= com_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder

module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_write  [2];
    logic [6:0]  req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_ready [2];
    logic        busy       [2];

    int n_checks;
    int n_fail;

    // Reference memory per instance: index 0 has 2 wait states, index 1 has none.
    logic [31:0] mdl   [2][128];
    bit          known [2][128];

    data_mem_responder #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_ready(resp_ready[0]), .busy(busy[0])
    );

    data_mem_responder #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_ready(resp_ready[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic void model_txn(input int d, input bit wr, input logic [6:0] a,
                                      input logic [31:0] wd);
        if (wr) begin
            mdl[d][a]   = wd;
            known[d][a] = 1'b1;
        end
    endfunction

    // One complete transaction. lat = number of rising edges from the
    // acceptance edge to the first edge that samples resp_valid high.
    task automatic do_txn(input int d, input bit wr, input logic [6:0] a, input logic [31:0] wd,
                          input int hold, input bit scramble,
                          output logic [31:0] rd, output int lat);
        int guard;
        rd  = 'x;
        lat = -1;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        guard = 0;
        while (req_ready[d] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout dut=%0d: req_ready never rose within 50 cycles", d);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        if (scramble) begin
            req_addr[d]  = a ^ 7'h03;
            req_wdata[d] = wd << 1;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid[d] !== 1'b1 && lat < 40);
        if (resp_valid[d] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout dut=%0d: resp_valid never rose within 40 cycles", d);
            lat = -1;
            return;
        end
        repeat (hold) @(negedge clk);
        rd = resp_rdata[d];
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
        model_txn(d, wr, a, wd);
    endtask

    task automatic test_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
                resp_rdata[d] !== 32'h0 || busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut=%0d: got rdy=%b vld=%b rdata=%h busy=%b, want 1 0 00000000 0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], busy[d]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int lat;
        do_txn(0, 1'b1, 7'h05, 32'hDEADBEEF, 0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'hDEADBEEF || lat !== 3) begin
            n_fail++;
            $display("FAIL write_echo: got rdata=%h lat=%0d, want DEADBEEF lat=3", rd, lat);
        end
        n_checks++;
        if (req_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL write_return_idle: got rdy=%b busy=%b, want 1 0", req_ready[0], busy[0]);
        end
        do_txn(0, 1'b0, 7'h05, 32'h0, 0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'hDEADBEEF || lat !== 3) begin
            n_fail++;
            $display("FAIL read_back: got rdata=%h lat=%0d, want DEADBEEF lat=3", rd, lat);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] rd;
        int lat;
        int guard;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 7'h05;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy[0] !== 1'b1 || req_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_busy_after_accept: got busy=%b rdy=%b, want 1 0", busy[0], req_ready[0]);
        end
        // Keep presenting a conflicting write; it must be ignored.
        req_write[0] = 1'b1;
        req_wdata[0] = 32'h0BAD0BAD;
        guard = 0;
        while (resp_valid[0] !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hDEADBEEF || req_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d: got vld=%b rdata=%h rdy=%b, want 1 DEADBEEF 0",
                         i, resp_valid[0], resp_rdata[0], req_ready[0]);
            end
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[0] = 1'b0;
        n_checks++;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b vld=%b busy=%b, want 1 0 0",
                     req_ready[0], resp_valid[0], busy[0]);
        end
        do_txn(0, 1'b0, 7'h05, 32'h0, 0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bp_ignored_write: got rdata=%h, want DEADBEEF", rd);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd;
        int lat;
        do_txn(1, 1'b1, 7'h7F, 32'h12345678, 0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'h12345678 || lat !== 1) begin
            n_fail++;
            $display("FAIL zw_write: got rdata=%h lat=%0d, want 12345678 lat=1", rd, lat);
        end
        do_txn(1, 1'b0, 7'h7F, 32'h0, 1, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'h12345678 || lat !== 1) begin
            n_fail++;
            $display("FAIL zw_read: got rdata=%h lat=%0d, want 12345678 lat=1", rd, lat);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd;
        int lat;
        do_txn(0, 1'b1, 7'h10, 32'h00000000, 0, 1'b0, rd, lat);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 7'h10;
        req_wdata[0] = 32'hAAAA5555;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'h0 || busy[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got vld=%b rdata=%h busy=%b rdy=%b, want 0 00000000 0 1",
                     resp_valid[0], resp_rdata[0], busy[0], req_ready[0]);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_txn(0, 1'b0, 7'h10, 32'h0, 0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'h00000000) begin
            n_fail++;
            $display("FAIL reset_mid_not_committed: got rdata=%h, want 00000000", rd);
        end
    endtask

    task automatic test_stale_fields();
        logic [31:0] rd;
        int lat;
        do_txn(0, 1'b1, 7'h02, 32'h0C0FFEE0, 0, 1'b0, rd, lat);
        do_txn(0, 1'b1, 7'h01, 32'h11111111, 0, 1'b1, rd, lat);
        n_checks++;
        if (rd !== 32'h11111111) begin
            n_fail++;
            $display("FAIL stale_echo: got rdata=%h, want 11111111", rd);
        end
        do_txn(0, 1'b0, 7'h01, 32'h0, 0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'h11111111) begin
            n_fail++;
            $display("FAIL stale_addr1: got rdata=%h, want 11111111", rd);
        end
        do_txn(0, 1'b0, 7'h02, 32'h0, 0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'h0C0FFEE0) begin
            n_fail++;
            $display("FAIL stale_addr2: got rdata=%h, want 0C0FFEE0", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] exp;
        logic [6:0]  a;
        logic [31:0] wd;
        bit          wr;
        bit          chk;
        int          lat;
        int          d;
        for (int i = 0; i < 60; i++) begin
            d   = int'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 1) == 1);
            a   = 7'($urandom_range(0, 15) == 0 ? 127 : $urandom_range(0, 127));
            wd  = $urandom;
            chk = wr || known[d][a];
            exp = wr ? wd : mdl[d][a];
            do_txn(d, wr, a, wd, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, lat);
            n_checks++;
            if (lat !== wc(d) + 1) begin
                n_fail++;
                $display("FAIL rand_latency i=%0d dut=%0d: got %0d, want %0d", i, d, lat, wc(d) + 1);
            end
            if (chk) begin
                n_checks++;
                if (rd !== exp) begin
                    n_fail++;
                    $display("FAIL rand_data i=%0d dut=%0d wr=%0d addr=%h: got %h, want %h",
                             i, d, wr, a, rd, exp);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        reset    = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            resp_ready[d] = 1'b0;
            for (int k = 0; k < 128; k++) begin
                known[d][k] = 1'b0;
                mdl[d][k]   = '0;
            end
        end
        test_reset();
        test_write_read();
        test_back_pressure();
        test_zero_wait();
        test_reset_mid_write();
        test_stale_fields();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
